div_sched_2ch: RTL and testbench

Two-requester scheduler for the pipelined 8-bit signed divider (`pipeline_theory_divider_module`). It arbitrates round-robin between two operand sources, issues at most one divide per clock, and tracks each in-flight operation with a tag pipeline matched to the divider latency. It routes each quotient/remainder pair back to the requester that issued it. The block sits between the requester logic and the divider; the divider is instantiated alongside it, not inside it.

---
 rtl/div_sched_2ch.sv | 102 ++++++++++
 tb/tb_div_sched_2ch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/div_sched_2ch.sv
// div_sched_2ch: round-robin two-requester issue scheduler for a pipelined 8-bit divider.
// Optional divide-by-zero flagging/forcing is enabled with `define DIV_SCHED_DZ_CHECK_EN.
module div_sched_2ch #(
  parameter int DIV_LATENCY = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sched_en,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_dividend0,
  input  logic [7:0] req_divisor0,
  input  logic [7:0] req_dividend1,
  input  logic [7:0] req_divisor1,
  output logic [7:0] div_dividend,
  output logic [7:0] div_divisor,
  input  logic [7:0] div_quotient,
  input  logic [7:0] div_reminder,
  output logic [1:0] rsp_valid,
  output logic [7:0] rsp_quotient,
  output logic [7:0] rsp_reminder,
  output logic       rsp_dz,
  output logic [3:0] in_flight
);
  // One tag per cycle from issue until the response register captures the result.
  localparam int D = DIV_LATENCY + 1;
  logic [7:0] div_dividend_q, div_dividend_d, div_divisor_q, div_divisor_d;
  logic [7:0] rsp_quotient_q, rsp_quotient_d, rsp_reminder_q, rsp_reminder_d;
  logic [1:0] rsp_valid_q, rsp_valid_d;
  logic [3:0] in_flight_q, in_flight_d;
  logic [D-1:0] tv_q, tv_d, tid_q, tid_d;
  logic lg_q, lg_d, gnt0, gnt1, xfer, last, zero;
`ifdef DIV_SCHED_DZ_CHECK_EN
  logic [D-1:0] tdz_q, tdz_d;
  logic rsp_dz_q, rsp_dz_d;
`endif
  always_comb begin
    gnt0 = sched_en & req_valid[0] & (~req_valid[1] | lg_q);
    gnt1 = sched_en & req_valid[1] & (~req_valid[0] | ~lg_q);
    req_ready = {gnt1, gnt0};
    xfer = gnt0 | gnt1;
    last = tv_q[D-1];
    div_dividend_d = xfer ? (gnt1 ? req_dividend1 : req_dividend0) : div_dividend_q;
    div_divisor_d = xfer ? (gnt1 ? req_divisor1 : req_divisor0) : div_divisor_q;
    lg_d = xfer ? gnt1 : lg_q;
    tv_d = {tv_q[D-2:0], xfer};
    tid_d = {tid_q[D-2:0], gnt1};
`ifdef DIV_SCHED_DZ_CHECK_EN
    tdz_d = {tdz_q[D-2:0], xfer & ((gnt1 ? req_divisor1 : req_divisor0) == 8'd0)};
    zero = tdz_q[D-1];
    rsp_dz_d = last & zero;
`else
    zero = 1'b0;
`endif
    rsp_valid_d = {last & tid_q[D-1], last & ~tid_q[D-1]};
    rsp_quotient_d = last ? (zero ? 8'h00 : div_quotient) : rsp_quotient_q;
    rsp_reminder_d = last ? (zero ? 8'h00 : div_reminder) : rsp_reminder_q;
    in_flight_d = in_flight_q + {3'b0, xfer} - {3'b0, last};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_dividend_q <= '0;
      div_divisor_q <= '0;
      rsp_quotient_q <= '0;
      rsp_reminder_q <= '0;
      rsp_valid_q <= '0;
      in_flight_q <= '0;
      tv_q <= '0;
      tid_q <= '0;
      lg_q <= 1'b1;
`ifdef DIV_SCHED_DZ_CHECK_EN
      tdz_q <= '0;
      rsp_dz_q <= 1'b0;
`endif
    end else begin
      div_dividend_q <= div_dividend_d;
      div_divisor_q <= div_divisor_d;
      rsp_quotient_q <= rsp_quotient_d;
      rsp_reminder_q <= rsp_reminder_d;
      rsp_valid_q <= rsp_valid_d;
      in_flight_q <= in_flight_d;
      tv_q <= tv_d;
      tid_q <= tid_d;
      lg_q <= lg_d;
`ifdef DIV_SCHED_DZ_CHECK_EN
      tdz_q <= tdz_d;
      rsp_dz_q <= rsp_dz_d;
`endif
    end
  end
  assign div_dividend = div_dividend_q;
  assign div_divisor = div_divisor_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_reminder = rsp_reminder_q;
  assign rsp_valid = rsp_valid_q;
  assign in_flight = in_flight_q;
`ifdef DIV_SCHED_DZ_CHECK_EN
  assign rsp_dz = rsp_dz_q;
`else
  assign rsp_dz = 1'b0;
`endif
endmodule

// File: tb/tb_div_sched_2ch.sv
// tb_div_sched_2ch: directed + random check of div_sched_2ch against a queue-based response model,
// with a behavioural pipelined divider standing in for the real one.
module tb_div_sched_2ch;
  localparam int L = 8;
  logic clk = 0, rst_n = 0, sched_en = 0;
  logic [1:0] req_valid = 0, req_ready, rsp_valid;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [7:0] div_dividend, div_divisor, div_quotient, div_reminder, rsp_quotient, rsp_reminder;
  logic rsp_dz;
  logic [3:0] in_flight;
  div_sched_2ch #(.DIV_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend0(a0), .req_divisor0(b0), .req_dividend1(a1), .req_divisor1(b1),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_reminder(div_reminder),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_reminder(rsp_reminder),
    .rsp_dz(rsp_dz), .in_flight(in_flight)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] dq(input logic [7:0] a, input logic [7:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    return (y == 0) ? 8'hFF : 8'(x / y);
  endfunction
  function automatic logic [7:0] dr(input logic [7:0] a, input logic [7:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    return (y == 0) ? a : 8'(x % y);
  endfunction
  // Divider stand-in: samples the operand bus each edge, result L edges later.
  logic [7:0] pq [L];
  logic [7:0] pr [L];
  always @(posedge clk) begin
    pq[0] <= dq(div_dividend, div_divisor);
    pr[0] <= dr(div_dividend, div_divisor);
    for (int i = 1; i < L; i++) begin
      pq[i] <= pq[i-1];
      pr[i] <= pr[i-1];
    end
  end
  assign div_quotient = pq[L-1];
  assign div_reminder = pr[L-1];
  typedef struct {int due; logic id; logic [7:0] q; logic [7:0] r; logic dz;} exp_t;
  exp_t eq[$];
  int cnt = 0, tests = 0, fails = 0;
  logic mlg = 1'b1;
  always @(posedge clk) cnt <= cnt + 1;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    exp_t e;
    logic [1:0] ev, er;
    logic [7:0] a, b;
    @(negedge clk);
    if (!rst_n) begin
      eq.delete();
      mlg = 1'b1;
    end
    ev = 2'b00;
    if (eq.size() != 0 && eq[0].due == cnt) begin
      e = eq.pop_front();
      ev = e.id ? 2'b10 : 2'b01;
      chk("rsp_quotient", rsp_quotient, e.q);
      chk("rsp_reminder", rsp_reminder, e.r);
      chk("rsp_dz", {7'b0, rsp_dz}, {7'b0, e.dz});
    end
    chk("rsp_valid", {6'b0, rsp_valid}, {6'b0, ev});
    chk("in_flight", {4'b0, in_flight}, 8'(eq.size()));
    er = 2'b00;
    if (sched_en) er = (&req_valid) ? (mlg ? 2'b01 : 2'b10) : req_valid;
    chk("req_ready", {6'b0, req_ready}, {6'b0, er});
    if (er != 2'b00 && rst_n) begin
      e.id = er[1];
      a = e.id ? a1 : a0;
      b = e.id ? b1 : b0;
      e.due = cnt + L + 2;
`ifdef DIV_SCHED_DZ_CHECK_EN
      e.dz = (b == 8'd0);
`else
      e.dz = 1'b0;
`endif
      e.q = e.dz ? 8'h00 : dq(a, b);
      e.r = e.dz ? 8'h00 : dr(a, b);
      eq.push_back(e);
      mlg = e.id;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc();
  endtask
  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b);
    if (id) begin a1 = a; b1 = b; end else begin a0 = a; b0 = b; end
    req_valid = id ? 2'b10 : 2'b01;
    cyc();
    req_valid = 2'b00;
  endtask
  initial begin
    idle(2);
    chk("rst_div_dividend", div_dividend, 8'h00);
    chk("rst_div_divisor", div_divisor, 8'h00);
    rst_n = 1'b1;
    sched_en = 1'b1;
    issue(0, 8'd7, 8'd2);
    idle(L + 2);
    issue(1, 8'h08, 8'hFD);
    idle(L + 2);
    a0 = 8'hED; b0 = 8'd6; a1 = 8'd7; b1 = 8'd2;
    req_valid = 2'b11;
    cyc();
    a0 = 8'h88; b0 = 8'hF9;
    cyc();
    a1 = 8'h08; b1 = 8'hFD;
    cyc();
    cyc();
    req_valid = 2'b00;
    idle(L + 2);
`ifdef DIV_SCHED_DZ_CHECK_EN
    issue(0, 8'd5, 8'd0);
    idle(L + 2);
    issue(0, 8'd7, 8'd2);
    idle(L + 2);
`endif
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      a0 = 8'($urandom);
      b0 = 8'($urandom_range(1, 255));
      cyc();
    end
    req_valid = 2'b00;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    idle(L + 3);
    req_valid = 2'b11;
    cyc();
    req_valid = 2'b00;
    idle(L + 2);
    issue(1, 8'd100, 8'd9);
    sched_en = 1'b0;
    req_valid = 2'b11;
    idle(L + 3);
    sched_en = 1'b1;
    req_valid = 2'b00;
    idle(2);
    for (int i = 0; i < 300; i++) begin
      req_valid = 2'($urandom);
      sched_en = ($urandom_range(0, 7) != 0);
      a0 = 8'($urandom);
      a1 = 8'($urandom);
      b0 = 8'($urandom_range(1, 255));
      b1 = 8'($urandom_range(1, 255));
      cyc();
    end
    req_valid = 2'b00;
    idle(L + 3);
    tests++;
    assert (eq.size() == 0) else begin
      fails++;
      $error("FAIL drain got=%0d exp=0", eq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
